// File: rtl/dualmem_pkg.sv
// Shared defaults and enums for the two-requester memory arbiter.
package dualmem_pkg;

   localparam int unsigned AW_DEF = 13;
   localparam int unsigned DW_DEF = 8;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dualmem_arb_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
module rr_arb2
   import dualmem_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic gnt0_c,
   output logic gnt1_c
);

   req_id_e last_q;

   // Sole requester always wins; contention goes to whoever was not granted last.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (en) begin
         if (valid0 && valid1) begin
            gnt0_c = (last_q == REQ1);
            gnt1_c = (last_q == REQ0);
         end else begin
            gnt0_c = valid0;
            gnt1_c = valid1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_q <= REQ1;
      end else if (gnt0_c) begin
         last_q <= REQ0;
      end else if (gnt1_c) begin
         last_q <= REQ1;
      end
   end

endmodule

// File: rtl/dualmem_arb.sv
// Arbitrates two requesters onto one synchronous memory port, with optional
// post-reset zero-fill of the whole memory.
module dualmem_arb
   import dualmem_pkg::*;
#(
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned DW        = DW_DEF,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          init_done
);

   localparam arb_state_e    RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
   localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

   arb_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          pend0_q, pend1_q;
   logic          gnt0_c, gnt1_c;
   logic          run_c;

   // Combinational strobes are gated by rstn so the memory sees nothing while reset is held.
   assign run_c = rstn && (state_q == ST_RUN);

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rstn   (rstn),
      .en     (run_c),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .gnt0_c (gnt0_c),
      .gnt1_c (gnt1_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend0_q <= gnt0_c;
         pend1_q <= gnt1_c;
      end
   end

   // Next state and memory port mux.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      req0_ready = gnt0_c;
      req1_ready = gnt1_c;
      case (state_q)
         ST_INIT: begin
            mem_en   = rstn;
            mem_we   = rstn;
            mem_addr = cnt_q;
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == ADDR_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (gnt0_c) begin
               mem_en    = 1'b1;
               mem_we    = req0_we;
               mem_addr  = req0_addr;
               mem_wdata = req0_wdata;
            end else if (gnt1_c) begin
               mem_en    = 1'b1;
               mem_we    = req1_we;
               mem_addr  = req1_addr;
               mem_wdata = req1_wdata;
            end
         end
      endcase
   end

   assign init_done  = (state_q == ST_RUN);
   assign rsp0_valid = pend0_q;
   assign rsp1_valid = pend1_q;
   assign rsp0_rdata = mem_rdata;
   assign rsp1_rdata = mem_rdata;

endmodule

// File: tb/tb_dualmem_arb.sv
// Randomised and directed checks of dualmem_arb against an array/queue reference model.
module tb_dualmem_arb;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          init_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            last_gnt;
   bit            pend0, pend1, pend_rd0, pend_rd1;
   logic [DW-1:0] exp_rd0, exp_rd1;

   // Physical memory attached to the port (stands in for the SRAM)
   logic [DW-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   dualmem_arb #(.AW(AW), .DW(DW), .INIT_ZERO(1'b1)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .init_done  (init_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      last_gnt = 1;
      pend0    = 1'b0;
      pend1    = 1'b0;
      pend_rd0 = 1'b0;
      pend_rd1 = 1'b0;
   endtask

   // Called at a falling edge: drives one cycle of requests, checks, advances the model.
   task automatic cycle(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      bit g0, g1;
      req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
      #1;
      check("init_done", init_done, 1);
      check("rsp0_valid", rsp0_valid, pend0);
      check("rsp1_valid", rsp1_valid, pend1);
      if (pend0 && pend_rd0) check("rsp0_rdata", rsp0_rdata, exp_rd0);
      if (pend1 && pend_rd1) check("rsp1_rdata", rsp1_rdata, exp_rd1);
      g0 = v0 && (!v1 || last_gnt == 1);
      g1 = v1 && !g0;
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("mem_en", mem_en, g0 || g1);
      if (g0 || g1) begin
         check("mem_we", mem_we, g0 ? w0 : w1);
         check("mem_addr", mem_addr, g0 ? a0 : a1);
         if (g0 ? w0 : w1) check("mem_wdata", mem_wdata, g0 ? d0 : d1);
      end
      pend0    = g0;
      pend1    = g1;
      pend_rd0 = g0 && !w0;
      pend_rd1 = g1 && !w1;
      if (g0) begin
         if (w0) ref_mem[a0] = d0; else exp_rd0 = ref_mem[a0];
         last_gnt = 0;
      end
      if (g1) begin
         if (w1) ref_mem[a1] = d1; else exp_rd1 = ref_mem[a1];
         last_gnt = 1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // Checks n zero-fill cycles starting at address 0 while both requesters push.
   task automatic fill_check(input int n);
      for (int i = 0; i < n; i++) begin
         req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'($urandom); req0_wdata = DW'($urandom);
         req1_valid = 1'b1; req1_we = 1'b0; req1_addr = AW'($urandom); req1_wdata = DW'($urandom);
         #1;
         check("fill_en", mem_en, 1);
         check("fill_we", mem_we, 1);
         check("fill_addr", mem_addr, i);
         check("fill_wdata", mem_wdata, 0);
         check("fill_ready0", req0_ready, 0);
         check("fill_ready1", req1_ready, 0);
         check("fill_done", init_done, 0);
         @(negedge clk);
      end
   endtask

   // Asserts reset mid-cycle, checks quiescent outputs, releases at the next falling edge.
   task automatic do_reset();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rstn = 1'b0;
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_rsp0", rsp0_valid, 0);
      check("rst_rsp1", rsp1_valid, 0);
      check("rst_done", init_done, 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(1, 255));
      mem_rdata  = '0;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      rstn = 1'b0;
      @(negedge clk);
      do_reset();

      // Zero-fill, then read address 5
      fill_check(16);
      zero_model();
      cycle(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
      idle();

      // req0 writes 0xA5 @3, req1 reads it back
      cycle(1'b1, 1'b1, AW'(3), 8'hA5, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(3), '0);
      check("rd_a5_valid", rsp1_valid, 1);
      check("rd_a5_data", rsp1_rdata, 32'hA5);
      idle();

      // Both valid for six cycles: alternate grants
      for (int i = 0; i < 6; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         check("alt_gnt0", req0_ready, (i % 2) == 0);
         #0;
         req0_valid = 1'b0; req1_valid = 1'b0;
         #(-1 + 1);
         cycle(1'b1, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1, 1'b0, AW'(i + 8), '0);
      end
      idle();

      // req1 alone three cycles, then a pair goes to req0
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      cycle(1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0, AW'(4), '0);
      idle();

      // Reset with a response pending, then reset again at fill address 7
      cycle(1'b1, 1'b1, AW'(9), 8'h3C, 1'b0, 1'b0, '0, '0);
      do_reset();
      fill_check(7);
      #1;
      check("fill_at7", mem_addr, 7);
      do_reset();
      fill_check(16);
      zero_model();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dualmem_arb.md
DUALMEM_ARB -- requirements
Module: dualmem_arb

Interface
REQ-001 SHALL have parameter AW, default 13, memory address width in bits.
REQ-002 SHALL have parameter DW, default 8, memory data width in bits.
REQ-003 SHALL have parameter INIT_ZERO, default 1, enabling the post-reset zero-fill of the whole memory.
REQ-004 SHALL have port clk  input  1  single clock for all logic; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  requester n presents a request.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  request n accepted this cycle.
REQ-008 SHALL have ports req0_we/req1_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports req0_addr/req1_addr  input  AW  word address.
REQ-010 SHALL have ports req0_wdata/req1_wdata  input  DW  write data.
REQ-011 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle completion pulse for requester n.
REQ-012 SHALL have ports rsp0_rdata/rsp1_rdata  output  DW  read data, qualified by rspn_valid after a read.
REQ-013 SHALL have ports mem_en, mem_we  output  1  enable and write strobe to one synchronous memory port.
REQ-014 SHALL have ports mem_addr  output  AW  and mem_wdata  output  DW  to the memory port.
REQ-015 SHALL have port mem_rdata  input  DW  memory port read data, valid the cycle after the enabled read.
REQ-016 SHALL have port init_done  output  1  high once zero-fill is complete (or immediately if INIT_ZERO=0).

Function
REQ-017 SHALL implement states INIT and RUN; INIT_ZERO=1 starts in INIT and INIT_ZERO=0 starts in RUN.
REQ-018 SHALL, in INIT, drive mem_en=1, mem_we=1, mem_wdata=0, mem_addr=counter, increment the counter each cycle from 0, and enter RUN after address 2^AW-1 (2^AW cycles exactly).
REQ-019 SHALL hold both reqn_ready low and init_done low while in INIT.
REQ-020 SHALL, in RUN, grant at most one request per cycle; reqn_ready is combinational and equals the grant.
REQ-021 SHALL grant the sole valid requester when only one reqn_valid is high, regardless of priority state.
REQ-022 SHALL, when both are valid, grant the requester not granted last (round-robin); the last-grant pointer updates only on a grant.
REQ-023 SHALL drive mem_en, mem_we, mem_addr and mem_wdata combinationally from the granted request; mem_en=0 with no grant.
REQ-024 SHALL pulse rspn_valid exactly one cycle after acceptance, for reads and writes, so latency is 1 cycle.
REQ-025 SHALL drive rspn_rdata = mem_rdata combinationally, meaningful only in the rspn_valid cycle following a read.
REQ-026 SHALL sustain back-to-back accepts: one request per cycle, alternating under contention, with no bubble.
REQ-027 SHALL NOT require a requester to hold valid stable before acceptance; requests may be withdrawn without effect.
REQ-028 SHALL wrap the INIT counter with AW-bit arithmetic; the transition to RUN is taken on the all-ones value.

Reset
REQ-029 SHALL, on rstn low, asynchronously clear reqn_ready, rspn_valid, mem_en, mem_we, the INIT counter and pending-response flags.
REQ-030 SHALL set the last-grant pointer to requester 1 on reset, so requester 0 wins the first contention.
REQ-031 SHALL restart INIT from address 0 when reset is asserted mid-fill, and discard any response pending at reset.

Structure
REQ-032 SHALL take AW/DW defaults and a two-value requester-id enum from a shared package dualmem_pkg.
REQ-033 SHALL contain one sub-module, rr_arb2, holding the two-way round-robin grant and pointer.

Verification
REQ-034 SHALL verify reset then INIT with AW=4: 16 cycles of zero writes at addresses 0..15, then init_done=1, after which a read of address 5 returns 0.
REQ-035 SHALL verify that req0 writing 0xA5 to address 3, followed by a req1 read of address 3, gives rsp1_valid one cycle after accept with rsp1_rdata=0xA5.
REQ-036 SHALL verify that both requesters held valid for 6 cycles produce grants 0,1,0,1,0,1 and six response pulses on the correct ports.
REQ-037 SHALL verify that reset asserted at INIT address 7 immediately gives mem_en=0 and that, after release, the fill restarts at address 0.
REQ-038 SHALL verify that req1 valid alone for 3 cycles is granted every cycle, and that a then-simultaneous pair is granted to req0.
